alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares one 32-bit MIPS ALU between NREQ requesters, such as the EX stage, a branch-compare unit and an address generator. Each requester uses a valid/ready handshake to present an op and two operands. The winner's operation runs on the single shared `alu` instance. The result returns one cycle later on a registered response channel tagged with the requester index.

## Interface
- `NREQ`, default 2 — number of requesters, range 2..8.
- `IDW`, default `$clog2(NREQ)` — requester-ID width; minimum 1.
- `clk`  in  1 — clock, rising edge.
- `rst_n`  in  1 — synchronous, active-low reset.
- `req_valid`  in  NREQ — bit i: requester i has an op pending.
- `req_ready`  out  NREQ — one-hot or zero grant; bit i high means requester i is accepted this cycle.
- `req_op`  in  3*NREQ — slice i is requester i's 3-bit ALU op.
- `req_in1`  in  32*NREQ — slice i is requester i's signed operand 1.
- `req_in2`  in  32*NREQ — slice i is requester i's signed operand 2.
- `rsp_valid`  out  1 — response register holds a result.
- `rsp_ready`  in  1 — consumer accepts the response this cycle.
- `rsp_id`  out  IDW — index of the requester that owns the response.
- `rsp_out`  out  32 — ALU result.
- `rsp_zero`  out  1 — high when `rsp_out` == 0.

## Operation
- **Slot free:** `slot_free` = `!rsp_valid || rsp_ready`.
- **Grant selection:** when `slot_free` and `rst_n` is high, grant the first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping modulo NREQ.
  - `req_ready` = one-hot of the granted i, combinational.
  - `req_ready` = 0 when no request is valid, the slot is not free, or `rst_n` is low.
- **Handshake:** a transfer happens when `req_valid[i] && req_ready[i]`.
  - Requesters hold op and operands stable while valid and not ready.
  - Requesters do not drop valid before the transfer.
- **On a transfer (next edge):**
  - `rsp_out`/`rsp_zero` <= ALU result computed from the granted slice.
  - `rsp_id` <= i, `rsp_valid` <= 1.
  - `rr_ptr` <= (i+1) mod NREQ.
- **Response drained, no grant:** if `rsp_ready` is high and nothing is granted, `rsp_valid` <= 0 and the data registers hold.
- **Fairness:** `rr_ptr` only changes on a grant. Every continuously valid requester is granted within NREQ consecutive grants.
- **Shared ALU semantics, by op:**
  - 000: AND.
  - 001: OR.
  - 010: add, wrap mod 2^32.
  - 011: constant 0.
  - 100: `in2 << in1`; the full 32-bit `in1` is the shift amount, so an amount ≥32 gives 0.
  - 101: `in2 >> in1`, logical; an amount ≥32 gives 0.
  - 110: `in1 - in2`, wrap mod 2^32.
  - 111: signed `in1 < in2`, giving 1 or 0.
- **Zero flag:** `rsp_zero` is computed on the result of every op.
- **Reset values:** `rsp_valid`=0, `rsp_id`=0, `rsp_out`=0, `rsp_zero`=0, `rr_ptr`=0. Any pending response is discarded.

## Timing
- **Latency:** exactly 1 cycle from transfer to `rsp_valid`.
- **Throughput:** 1 op per cycle while `rsp_ready` stays high. Grant and drain can happen in the same cycle.
- **Backpressure:** while `rsp_valid && !rsp_ready`, all `req_ready` are 0 and `rsp_*` hold stable.
- **Combinational paths:** `req_ready` depends on `req_valid`, `rsp_valid`, `rsp_ready` and `rr_ptr`, with no register stage. `rsp_*` are fully registered.
- **Reset mid-operation:** while `rst_n` is low, `req_ready`=0. At the first edge with `rst_n` high after reset, the search starts at requester 0.

## Structure
- **Shared package `mips_pkg`:**
  - op constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_ZERO`, `ALU_SLL`, `ALU_SRL`, `ALU_SUB`, `ALU_SLT`;
  - a 3-bit `alu_op_t` typedef.
- **Sub-module:** one instance of the existing combinational `alu`.
- **In this block:** the operand mux, the round-robin selector as a function, and the response register stage.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `req_valid`=11 → `req_ready`=00 and `rsp_valid`=0 throughout. On the first cycle after release, `req_ready`=01.
- **Single add:** requester 1 alone, op 010, 5+7 → `req_ready`=10 that cycle. Next cycle `rsp_valid`=1, `rsp_id`=1, `rsp_out`=12, `rsp_zero`=0.
- **Contention:** both requesters continuously valid, `rsp_ready`=1 → grants alternate 0,1,0,1 and a response arrives every cycle with `rsp_id` alternating.
- **Backpressure:** `rsp_valid`=1 and `rsp_ready`=0 for 3 cycles → `req_ready`=00 and `rsp_*` unchanged. In the cycle `rsp_ready` rises, the next requester is granted.
- **ALU ops through the arbiter:**
  - sub 3-3 → 0, `rsp_zero`=1;
  - slt -1,1 → 1;
  - sll with `in1`=4, `in2`=1 → 16;
  - srl with `in1`=1, `in2`=32'h80000000 → 32'h40000000;
  - sll with `in1`=32 → 0;
  - op 011 → 0, `rsp_zero`=1.
- **Reset mid-operation:** pending `rsp_valid`=1 with `rr_ptr`=1, then `rst_n`=0 for one edge → `rsp_valid`=0. After release, requester 0 wins when both are valid.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS ALU definitions: op encoding and small helpers used by the ALU
// and by blocks that feed it.
package mips_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 3'b000;
  localparam alu_op_t ALU_OR   = 3'b001;
  localparam alu_op_t ALU_ADD  = 3'b010;
  localparam alu_op_t ALU_ZERO = 3'b011;
  localparam alu_op_t ALU_SLL  = 3'b100;
  localparam alu_op_t ALU_SRL  = 3'b101;
  localparam alu_op_t ALU_SUB  = 3'b110;
  localparam alu_op_t ALU_SLT  = 3'b111;

  localparam int unsigned DATA_W = 32;

  function automatic logic is_zero(input logic [DATA_W-1:0] value);
    return (value == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit MIPS ALU. Shift amounts use the full in1 operand, so
// any amount of 32 or more yields zero.
module alu
  import mips_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        zero
);

  logic shift_ovf_s;

  // Result select for each op code
  always_comb begin
    shift_ovf_s = (in1 >= 32'd32);
    case (op)
      ALU_AND:  out = in1 & in2;
      ALU_OR:   out = in1 | in2;
      ALU_ADD:  out = in1 + in2;
      ALU_ZERO: out = 32'd0;
      ALU_SLL:  out = shift_ovf_s ? 32'd0 : (in2 << in1[4:0]);
      ALU_SRL:  out = shift_ovf_s ? 32'd0 : (in2 >> in1[4:0]);
      ALU_SUB:  out = in1 - in2;
      ALU_SLT:  out = ($signed(in1) < $signed(in2)) ? 32'd1 : 32'd0;
      default:  out = 32'd0;
    endcase
    zero = is_zero(out);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ valid/ready requesters;
// results come back one cycle later on a registered, ID-tagged response.
module alu_arbiter
  import mips_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_in1,
  input  logic [32*NREQ-1:0]   req_in2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_out,
  output logic                 rsp_zero
);

  // Two passes: first the requesters at or above the pointer, then the wrap.
  function automatic logic [NREQ-1:0] rr_select(input logic [NREQ-1:0] valid,
                                                input logic [IDW-1:0]  ptr);
    logic [NREQ-1:0] grant;
    logic            found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && (IDW'(i) >= ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && (IDW'(i) < ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
    logic [IDW-1:0] nxt;
    if (idx == IDW'(NREQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + 1'b1;
    end
    return nxt;
  endfunction

  logic            slot_free_s;
  logic            xfer_s;
  logic [NREQ-1:0] pick_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  gnt_idx_s;
  alu_op_t         op_s;
  logic [31:0]     in1_s;
  logic [31:0]     in2_s;
  logic [31:0]     alu_out_s;
  logic            alu_zero_s;

  logic [IDW-1:0]  rr_ptr_r;
  logic            rsp_valid_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [31:0]     rsp_out_r;
  logic            rsp_zero_r;

  // Grant selection and one-hot AND-OR operand mux
  always_comb begin
    slot_free_s = !rsp_valid_r || rsp_ready;
    pick_s      = rr_select(req_valid, rr_ptr_r);
    grant_s     = (slot_free_s && rst_n) ? pick_s : '0;
    xfer_s      = |grant_s;
    gnt_idx_s   = '0;
    op_s        = '0;
    in1_s       = 32'd0;
    in2_s       = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_idx_s = gnt_idx_s | ({IDW{grant_s[i]}} & IDW'(i));
      op_s      = op_s      | ({3{grant_s[i]}}   & req_op[3*i +: 3]);
      in1_s     = in1_s     | ({32{grant_s[i]}}  & req_in1[32*i +: 32]);
      in2_s     = in2_s     | ({32{grant_s[i]}}  & req_in2[32*i +: 32]);
    end
  end

  alu u_alu (
    .op   (op_s),
    .in1  (in1_s),
    .in2  (in2_s),
    .out  (alu_out_s),
    .zero (alu_zero_s)
  );

  // Response register and round-robin pointer; pointer moves only on a grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_out_r   <= 32'd0;
      rsp_zero_r  <= 1'b0;
    end else if (xfer_s) begin
      rr_ptr_r    <= next_ptr(gnt_idx_s);
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= gnt_idx_s;
      rsp_out_r   <= alu_out_s;
      rsp_zero_r  <= alu_zero_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_out   = rsp_out_r;
  assign rsp_zero  = rsp_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_alu_arbiter;
  import mips_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_in1;
  logic [32*NREQ-1:0]   req_in2;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_out;
  logic                 rsp_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference state
  logic        m_valid = 1'b0;
  int          m_id    = 0;
  logic [31:0] m_out   = 32'd0;
  logic        m_zero  = 1'b0;
  int          m_ptr   = 0;

  // values seen at the most recent sample point
  logic [NREQ-1:0] obs_ready;
  logic            obs_valid;
  logic [31:0]     obs_id;
  logic [31:0]     obs_out;
  logic            obs_zero;
  int              last_grant;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return 32'd0;
      3'd4:    return b << a;
      3'd5:    return b >> a;
      3'd6:    return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
  endfunction

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = v;
    req_op[i*3 +: 3]    = op;
    req_in1[i*32 +: 32] = a;
    req_in2[i*32 +: 32] = b;
  endtask

  // One clock: compare at negedge, advance the model, step past posedge.
  task automatic tick();
    logic [NREQ-1:0] eg;
    int gi;
    @(negedge clk);
    eg = '0;
    gi = -1;
    if (rst_n && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    obs_ready = req_ready;
    obs_valid = rsp_valid;
    obs_id    = 32'(rsp_id);
    obs_out   = rsp_out;
    obs_zero  = rsp_zero;
    check_eq("req_ready", 32'(req_ready), 32'(eg));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check_eq("rsp_id",    32'(rsp_id),    32'(m_id));
    check_eq("rsp_out",   rsp_out,        m_out);
    check_eq("rsp_zero",  32'(rsp_zero),  32'(m_zero));
    if (!rst_n) begin
      m_valid = 1'b0; m_id = 0; m_out = 32'd0; m_zero = 1'b0; m_ptr = 0;
    end else if (gi >= 0) begin
      m_out   = alu_ref(req_op[gi*3 +: 3], req_in1[gi*32 +: 32], req_in2[gi*32 +: 32]);
      m_zero  = (m_out == 32'd0);
      m_id    = gi;
      m_valid = 1'b1;
      m_ptr   = (gi + 1) % NREQ;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    last_grant = gi;
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  t_op  [6] = '{ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SLL, ALU_ZERO};
  logic [31:0] t_a   [6] = '{32'd3, 32'hFFFF_FFFF, 32'd4, 32'd1, 32'd32, 32'd5};
  logic [31:0] t_b   [6] = '{32'd3, 32'd1, 32'd1, 32'h8000_0000, 32'd1, 32'd6};
  logic [31:0] t_exp [6] = '{32'd0, 32'd1, 32'd16, 32'h4000_0000, 32'd0, 32'd0};
  logic        t_z   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_in1   = '0;
    req_in2   = '0;

    // reset held with both requesters valid
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    set_req(1, 1'b1, ALU_OR,  32'd3, 32'd4);
    repeat (2) begin
      tick();
      check_eq("rst_ready", 32'(obs_ready), 32'd0);
      check_eq("rst_valid", 32'(obs_valid), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("rel_grant", 32'(obs_ready), 32'd1);
    req_valid = '0;
    tick();

    // single add from requester 1
    set_req(1, 1'b1, ALU_ADD, 32'd5, 32'd7);
    tick();
    check_eq("add_grant", 32'(obs_ready), 32'd2);
    req_valid[1] = 1'b0;
    tick();
    check_eq("add_valid", 32'(obs_valid), 32'd1);
    check_eq("add_id",    obs_id,         32'd1);
    check_eq("add_out",   obs_out,        32'd12);
    check_eq("add_zero",  32'(obs_zero),  32'd0);

    // contention: grants alternate, responses every cycle
    set_req(0, 1'b1, 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
    set_req(1, 1'b1, 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("cont_grant", 32'(obs_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) check_eq("cont_id", obs_id, 32'((k - 1) % 2));
      if (last_grant >= 0)
        set_req(last_grant, 1'b1, 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
    end

    // backpressure holds everything
    rsp_ready = 1'b0;
    repeat (3) begin
      tick();
      check_eq("bp_ready", 32'(obs_ready), 32'd0);
      check_eq("bp_valid", 32'(obs_valid), 32'd1);
      check_eq("bp_id",    obs_id,         32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_release", 32'(obs_ready), 32'd1);
    req_valid = '0;
    tick();

    // ALU corner cases through requester 0
    for (int t = 0; t < 6; t++) begin
      set_req(0, 1'b1, t_op[t], t_a[t], t_b[t]);
      tick();
      req_valid[0] = 1'b0;
      tick();
      check_eq("op_out",  obs_out,        t_exp[t]);
      check_eq("op_zero", 32'(obs_zero),  32'(t_z[t]));
    end

    // reset while a response is pending and rr_ptr points at requester 1
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    check_eq("mid_pend", 32'(obs_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, ALU_OR,  32'd8, 32'd1);
    set_req(1, 1'b1, ALU_AND, 32'd8, 32'd1);
    tick();
    check_eq("mid_valid", 32'(obs_valid), 32'd0);
    check_eq("mid_grant", 32'(obs_ready), 32'd1);
    if (last_grant >= 0) req_valid[last_grant] = 1'b0;

    // random traffic with occasional reset and backpressure
    for (int n = 0; n < 400; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'b1, 3'($urandom_range(0, 7)), rand_opnd(), rand_opnd());
      end
      tick();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
